// File: rtl/window_stats_if.sv
// window_stats_if: request/result and sample-memory signals of window_stats.
interface window_stats_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic          start;
  logic [AW-1:0] si;
  logic [AW-1:0] ei;
  logic          mode;
  logic [AW-1:0] index;
  logic [DW-1:0] value;
  logic          busy;
  logic          done;
  logic          err;
  logic          sat;
  logic [DW-1:0] mean;
  logic [DW-1:0] variance;
  logic [DW-1:0] min;
  logic [DW-1:0] max;
  modport master (
    output start, si, ei, mode, value,
    input  index, busy, done, err, sat, mean, variance, min, max
  );
  modport slave (
    input  start, si, ei, mode, value,
    output index, busy, done, err, sat, mean, variance, min, max
  );
endinterface

// File: rtl/window_stats.sv
// window_stats: mean, mean-absolute/squared deviation, min and max over a sample window,
// using two accumulate passes each followed by a bit-serial restoring division by N.
module window_stats #(
  parameter int DW    = 32,
  parameter int AW    = 32,
  parameter int ACC_W = 64
) (
  input logic clk,
  input logic rst_n,
  window_stats_if.slave bus
);
  localparam int CW = $clog2(ACC_W);
  typedef enum logic [2:0] {IDLE, ACC1, DIV1, ACC2, DIV2} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] idx_q, idx_d, si_q, si_d, ei_q, ei_d, n_q, n_d, rem_q, rem_d;
  logic [ACC_W-1:0] acc_q, acc_d, term, quo;
  logic [ACC_W:0] sum;
  logic [AW:0] rem_sh;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] mean_q, mean_d, var_q, var_d, min_q, min_d, max_q, max_d, diff;
  logic [2*DW-1:0] sq;
  logic mode_q, mode_d, busy_q, busy_d, done_q, done_d, err_q, err_d, sat_q, sat_d, ge, big;
  always_comb begin
    diff = bus.value >= mean_q ? bus.value - mean_q : mean_q - bus.value;
    sq = {{DW{1'b0}}, diff} * {{DW{1'b0}}, diff};
    term = (state_q == ACC1) ? ACC_W'(bus.value) : (mode_q ? ACC_W'(sq) : ACC_W'(diff));
    sum = {1'b0, acc_q} + {1'b0, term};
    // Dividend shifts out of the accumulator MSB while quotient bits shift into its LSB.
    rem_sh = {rem_q, acc_q[ACC_W-1]};
    ge = rem_sh >= {1'b0, n_q};
    quo = {acc_q[ACC_W-2:0], ge};
    big = |quo[ACC_W-1:DW];
  end
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    si_d = si_q;
    ei_d = ei_q;
    n_d = n_q;
    mode_d = mode_q;
    acc_d = acc_q;
    rem_d = rem_q;
    cnt_d = cnt_q;
    mean_d = mean_q;
    var_d = var_q;
    min_d = min_q;
    max_d = max_q;
    busy_d = busy_q;
    done_d = 1'b0;
    err_d = err_q;
    sat_d = sat_q;
    case (state_q)
      IDLE: if (bus.start) begin
        if (bus.ei > bus.si) begin
          si_d = bus.si;
          ei_d = bus.ei;
          n_d = bus.ei - bus.si;
          mode_d = bus.mode;
          idx_d = bus.si;
          acc_d = '0;
          min_d = '1;
          max_d = '0;
          err_d = 1'b0;
          sat_d = 1'b0;
          busy_d = 1'b1;
          state_d = ACC1;
        end else begin
          done_d = 1'b1;
          err_d = 1'b1;
          sat_d = 1'b0;
          mean_d = '0;
          var_d = '0;
          min_d = '0;
          max_d = '0;
        end
      end
      ACC1, ACC2: begin
        acc_d = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
        sat_d = sat_q | sum[ACC_W];
        idx_d = idx_q + AW'(1);
        if (state_q == ACC1) begin
          min_d = bus.value < min_q ? bus.value : min_q;
          max_d = bus.value > max_q ? bus.value : max_q;
        end
        if (idx_q == ei_q - AW'(1)) begin
          state_d = (state_q == ACC1) ? DIV1 : DIV2;
          cnt_d = '0;
          rem_d = '0;
        end
      end
      DIV1, DIV2: begin
        acc_d = quo;
        rem_d = AW'(ge ? rem_sh - {1'b0, n_q} : rem_sh);
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ACC_W - 1)) begin
          if (state_q == DIV1) begin
            mean_d = quo[DW-1:0];
            acc_d = '0;
            idx_d = si_q;
            state_d = ACC2;
          end else begin
            var_d = big ? '1 : quo[DW-1:0];
            sat_d = sat_q | big;
            done_d = 1'b1;
            busy_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      si_q <= '0;
      ei_q <= '0;
      n_q <= '0;
      mode_q <= 1'b0;
      acc_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      mean_q <= '0;
      var_q <= '0;
      min_q <= '0;
      max_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      sat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      si_q <= si_d;
      ei_q <= ei_d;
      n_q <= n_d;
      mode_q <= mode_d;
      acc_q <= acc_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
      mean_q <= mean_d;
      var_q <= var_d;
      min_q <= min_d;
      max_q <= max_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
      sat_q <= sat_d;
    end
  end
  assign bus.index = idx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err = err_q;
  assign bus.sat = sat_q;
  assign bus.mean = mean_q;
  assign bus.variance = var_q;
  assign bus.min = min_q;
  assign bus.max = max_q;
endmodule

// File: tb/tb_window_stats.sv
// tb_window_stats: randomized and directed requests; expected results come from a
// wide-arithmetic reference model and are checked by a done-driven scoreboard monitor.
module tb_window_stats;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int ACC_W = 64;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  window_stats_if #(.DW(DW), .AW(AW)) bus();
  window_stats #(.DW(DW), .AW(AW), .ACC_W(ACC_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [DW-1:0] mem [16];
  assign bus.value = mem[bus.index[3:0]];
  typedef struct {
    logic [DW-1:0] mean, var_, mn, mx;
    logic err, sat;
    int due;
  } exp_t;
  exp_t q[$];
  int cyc = 0, tests = 0, fails = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask
  function automatic exp_t model(input int s, input int e, input bit m, input int base);
    exp_t r;
    logic [127:0] s1, s2, d, qv;
    int n;
    n = e - s;
    r.err = (e <= s);
    r.sat = 1'b0;
    r.due = base;
    r.mean = '0; r.var_ = '0; r.mn = '0; r.mx = '0;
    if (r.err) return r;
    s1 = 0; s2 = 0; r.mn = '1;
    for (int i = s; i < e; i++) begin
      s1 += 128'(mem[i]);
      if (mem[i] < r.mn) r.mn = mem[i];
      if (mem[i] > r.mx) r.mx = mem[i];
    end
    r.mean = DW'(s1 / 128'(n));
    for (int i = s; i < e; i++) begin
      d = mem[i] > r.mean ? 128'(mem[i] - r.mean) : 128'(r.mean - mem[i]);
      s2 += m ? d * d : d;
    end
    if (s2 > 128'(64'hFFFF_FFFF_FFFF_FFFF)) begin
      s2 = 128'(64'hFFFF_FFFF_FFFF_FFFF);
      r.sat = 1'b1;
    end
    qv = s2 / 128'(n);
    if (qv > 128'(32'hFFFF_FFFF)) begin
      r.var_ = '1;
      r.sat = 1'b1;
    end else r.var_ = qv[DW-1:0];
    r.due = base + 2 * n + 2 * ACC_W;
    return r;
  endfunction
  always @(negedge clk) if (rst_n && bus.done) begin
    if (q.size() == 0) begin
      tests++; fails++;
      $display("FAIL spurious_done actual=1 required=0");
    end else begin
      exp_t e;
      e = q.pop_front();
      chk("latency", 64'(cyc), 64'(e.due));
      chk("mean", 64'(bus.mean), 64'(e.mean));
      chk("variance", 64'(bus.variance), 64'(e.var_));
      chk("min", 64'(bus.min), 64'(e.mn));
      chk("max", 64'(bus.max), 64'(e.mx));
      chk("err", 64'(bus.err), 64'(e.err));
      chk("sat", 64'(bus.sat), 64'(e.sat));
      chk("busy_at_done", 64'(bus.busy), 64'(0));
    end
  end
  task automatic issue(input int s, input int e, input bit m);
    @(negedge clk);
    bus.start = 1'b1; bus.si = AW'(s); bus.ei = AW'(e); bus.mode = m;
    q.push_back(model(s, e, m, cyc + 1));
    @(negedge clk);
    bus.start = 1'b0; bus.si = $urandom; bus.ei = $urandom; bus.mode = 1'($urandom);
    chk("busy_after_accept", 64'(bus.busy), 64'(e > s));
  endtask
  task automatic wait_idle();
    for (int k = 0; k < 2000 && (bus.busy || q.size() != 0); k++) @(negedge clk);
    tests++;
    if (bus.busy || q.size() != 0) begin
      fails++;
      $display("FAIL timeout actual=busy%0d/pending%0d required=idle", bus.busy, q.size());
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_index"}, 64'(bus.index), 64'(0));
    chk({tag, "_busy"}, 64'(bus.busy), 64'(0));
    chk({tag, "_done"}, 64'(bus.done), 64'(0));
    chk({tag, "_flags"}, 64'({bus.err, bus.sat}), 64'(0));
    chk({tag, "_mean"}, 64'(bus.mean), 64'(0));
    chk({tag, "_variance"}, 64'(bus.variance), 64'(0));
    chk({tag, "_minmax"}, {bus.min, bus.max}, 64'(0));
  endtask
  task automatic load_ref();
    logic [DW-1:0] d [8];
    d = '{2, 4, 4, 4, 5, 5, 7, 9};
    for (int i = 0; i < 16; i++) mem[i] = i < 8 ? d[i] : DW'($urandom);
  endtask
  initial begin
    bus.start = 1'b0; bus.si = '0; bus.ei = '0; bus.mode = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    load_ref();
    issue(0, 8, 1'b1); wait_idle();
    issue(0, 8, 1'b0); wait_idle();
    issue(5, 5, 1'b1); wait_idle();
    issue(7, 3, 1'b0); wait_idle();
    mem[0] = '0; mem[1] = '1;
    issue(0, 2, 1'b1); wait_idle();
    load_ref();
    issue(0, 8, 1'b1);
    repeat (8) @(negedge clk);
    bus.start = 1'b1; bus.si = '0; bus.ei = AW'(2);
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
    issue(0, 8, 1'b1);
    repeat (69) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("midreset");
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    issue(0, 8, 1'b1); wait_idle();
    for (int t = 0; t < 25; t++) begin
      bit wide;
      int s, e;
      wide = 1'($urandom);
      for (int i = 0; i < 16; i++) mem[i] = wide ? DW'($urandom) : DW'($urandom_range(0, 20));
      s = $urandom_range(0, 15);
      e = $urandom_range(0, 16);
      issue(s, e, 1'($urandom));
      wait_idle();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/window_stats.md
WINDOW_STATS -- requirements
Module: window_stats

Interface
REQ-001 Parameter DW, default 32: sample width; samples are unsigned.
REQ-002 Parameter AW, default 32: index width.
REQ-003 Parameter ACC_W, default 64: accumulator and divider width; SHALL be >= 2*DW.
REQ-004 Clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 Rst  input  1  reset, asynchronous and active-low.
REQ-006 si  input  AW  window start index, inclusive; sampled with start.
REQ-007 ei  input  AW  window end index, exclusive; sampled with start.
REQ-008 mode  input  1  deviation mode, sampled with start: 0 = mean absolute deviation, 1 = squared deviation (variance).
REQ-009 index  output  AW  sample read address.
REQ-010 value  input  DW  sample at index, combinational from index in the same cycle.
REQ-011 start  input  1  request; accepted only when busy=0.
REQ-012 busy  output  1  high from acceptance until done rises.
REQ-013 done  output  1  one-cycle completion pulse; results valid from that cycle until the next acceptance.
REQ-014 err  output  1  empty window (ei <= si); valid with done.
REQ-015 sat  output  1  an accumulator or the variance result saturated; valid with done.
REQ-016 mean, variance, min, max  outputs  DW each  window statistics.

Function
REQ-017 States: IDLE, ACC1, DIV1, ACC2, DIV2; N = ei - si.
- Edge E0 samples start=1 in IDLE.
- All timing below counts edges after E0.
REQ-018 IDLE, start=1, ei > si:
- Latch si, ei, mode.
- index <= si, accumulator <= 0, min <= all-ones, max <= 0.
- Clear err and sat; busy <= 1; go to ACC1.
REQ-019 IDLE, start=1, ei <= si:
- Stay in IDLE; busy stays 0.
- At E0: done <= 1, err <= 1; mean, variance, min, max <= 0.
REQ-020 ACC1, edges 1..N:
- accumulator += value; update min/max; index++.
- The edge that accumulates index ei-1 moves to DIV1.
REQ-021 DIV1 is a restoring division (accumulator / N) over exactly ACC_W edges (N+1..N+ACC_W).
- The last edge writes mean = quotient[DW-1:0].
- The same edge sets index <= si, clears the accumulator and moves to ACC2.
REQ-022 ACC2, edges N+ACC_W+1..2N+ACC_W:
- accumulator += |value - mean| when mode=0, or (value - mean)^2 when mode=1.
- Differences use the exact absolute value; the last sample moves to DIV2.
REQ-023 DIV2 divides accumulator by N over ACC_W edges. At edge 2N+2*ACC_W:
- Write variance; done <= 1; busy <= 0; return to IDLE.
- Done latency is 2N + 2*ACC_W edges.
REQ-024 Saturation:
- Any accumulation that would exceed 2^ACC_W-1 holds the accumulator at 2^ACC_W-1 and sets sat.
- A DIV2 quotient above 2^DW-1 sets variance to 2^DW-1 and sets sat.
REQ-025 Division truncates toward zero; mean never exceeds 2^DW-1, so it needs no saturation.
REQ-026 done is high for exactly one cycle per accepted start (including the err case). It is 0 in every other cycle.
REQ-027 start is ignored while busy=1: no restart, and latched si/ei/mode are unchanged.
REQ-028 index is held at its last value in IDLE.
REQ-029 Input changes on si, ei or mode after acceptance have no effect.

Reset
REQ-030 Rst low, at any time (including mid-operation):
- Forces IDLE immediately.
- index, busy, done, err, sat, mean, variance, min, max, accumulator and divider state all go to 0.
REQ-031 The first start accepted after reset release runs a complete, unaffected computation.

Verification
REQ-032 Memory {2,4,4,4,5,5,7,9}, si=0, ei=8, mode=1, ACC_W=64:
- done at edge 144.
- mean=5, variance=4, min=2, max=9, err=0, sat=0.
REQ-033 Same data, mode=0 -> mean=5, variance=1 (12/8 truncated), done at edge 144.
REQ-034 si=5, ei=5 -> done at E0 with err=1, busy never rises, outputs 0; same result for si=7, ei=3.
REQ-035 DW=32, memory {0, 0xFFFFFFFF}, si=0, ei=2, mode=1:
- mean=0x7FFFFFFF, variance=0xFFFFFFFF, sat=1.
REQ-036 Run REQ-032, pulse start with si=0, ei=2 at edge 10 -> ignored, REQ-032 results unchanged.
REQ-037 Assert Rst at edge 70 of REQ-032:
- All outputs 0 and state IDLE.
- Re-issuing the request yields REQ-032 results at edge 144 after the new E0.
